// File: rtl/noc_fifo.sv
// Single-clock flit FIFO for NoC router ports: circular buffer, registered read data,
// occupancy flags straight off the count register, and sticky overflow/underflow.
module noc_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int AFULL_LVL = DEPTH - 2,
    localparam int CW       = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic [CW-1:0]     count,
    output logic              overflow,
    output logic              underflow
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              wr_ok;
    logic              rd_ok;

    // A write into a full FIFO is still accepted when a read frees the oldest slot on the same edge.
    assign wr_ok = write && (!full || read);
    assign rd_ok = read && !empty;

    assign empty       = (count == CW'(0));
    assign full        = (count == CW'(DEPTH));
    assign almost_full = (count >= CW'(AFULL_LVL));

    // Storage is deliberately left out of reset; an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else begin
            unique case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= rd_ok;
            if (rd_ok) begin
                data_out <= mem[rd_ptr];
            end
        end
    end

    // Error flags are sticky until reset; a simultaneous opposite request excuses the access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write && full && !read) begin
                overflow <= 1'b1;
            end
            if (read && empty && !write) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_noc_fifo.sv
// Directed self-checking bench for noc_fifo (DATA_W=8, DEPTH=8, AFULL_LVL=6).
module tb_noc_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int AFULL  = 6;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              write;
    logic [DATA_W-1:0] data_in;
    logic              read;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              underflow;

    int n_tests = 0;
    int n_fail  = 0;

    noc_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_LVL(AFULL)) dut (
        .clk        (clk),
        .rst        (rst),
        .write      (write),
        .data_in    (data_in),
        .read       (read),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .full       (full),
        .empty      (empty),
        .almost_full(almost_full),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one request set, let one rising edge take it, then sample 1 time unit later.
    task automatic step(input logic w, input logic [DATA_W-1:0] d, input logic r);
        write   = w;
        data_in = d;
        read    = r;
        @(posedge clk);
        #1;
        write = 1'b0;
        read  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b0;
        write   = 1'b0;
        read    = 1'b0;
        data_in = '0;
        #3;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_afull", 32'(almost_full), 0);
        chk("rst_dout", 32'(data_out), 0);
        chk("rst_valid", 32'(valid_out), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_udf", 32'(underflow), 0);
        @(negedge clk);
        rst = 1'b1;

        // Fill and drain with flag tracking
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 8'(i), 1'b0);
            chk("fill_count", 32'(count), 32'(i));
            chk("fill_afull", 32'(almost_full), (i >= 6) ? 1 : 0);
            chk("fill_full", 32'(full), (i == 8) ? 1 : 0);
            chk("fill_empty", 32'(empty), 0);
        end

        step(1'b1, 8'hAA, 1'b0);
        chk("ovf_count", 32'(count), 8);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_full", 32'(full), 1);

        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 8'h00, 1'b1);
            chk("drain_data", 32'(data_out), 32'(i));
            chk("drain_valid", 32'(valid_out), 1);
            chk("drain_count", 32'(count), 32'(8 - i));
        end
        chk("drain_empty", 32'(empty), 1);
        chk("ovf_sticky", 32'(overflow), 1);

        // Underflow, then read+write on empty
        step(1'b0, 8'h00, 1'b1);
        chk("udf_flag", 32'(underflow), 1);
        chk("udf_valid", 32'(valid_out), 0);
        chk("udf_count", 32'(count), 0);
        chk("udf_hold", 32'(data_out), 8);
        step(1'b1, 8'h5C, 1'b1);
        chk("erw_valid", 32'(valid_out), 0);
        chk("erw_count", 32'(count), 1);
        chk("erw_empty", 32'(empty), 0);
        step(1'b0, 8'h00, 1'b1);
        chk("erw_data", 32'(data_out), 32'h5C);
        chk("erw_rvalid", 32'(valid_out), 1);
        chk("erw_rcount", 32'(count), 0);
        step(1'b0, 8'h00, 1'b0);
        chk("idle_valid", 32'(valid_out), 0);
        chk("idle_hold", 32'(data_out), 32'h5C);

        // Read+write while full
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
        chk("frw_pre_full", 32'(full), 1);
        step(1'b1, 8'h99, 1'b1);
        chk("frw_data", 32'(data_out), 32'h10);
        chk("frw_valid", 32'(valid_out), 1);
        chk("frw_count", 32'(count), 8);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 8'h00, 1'b1);
            chk("frw_order", 32'(data_out), (i < 7) ? 32'(8'h11 + i) : 32'h99);
        end
        chk("frw_empty", 32'(empty), 1);

        // Wrap-around at occupancy 3
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 8'(8'h23 + k), 1'b1);
            chk("wrap_data", 32'(data_out), 32'(8'h20 + k));
            chk("wrap_count", 32'(count), 3);
        end
        chk("wrap_afull", 32'(almost_full), 0);

        // Asynchronous reset between edges at count 5
        step(1'b1, 8'h50, 1'b0);
        step(1'b1, 8'h51, 1'b0);
        chk("ar_pre_count", 32'(count), 5);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_count", 32'(count), 0);
        chk("ar_empty", 32'(empty), 1);
        chk("ar_dout", 32'(data_out), 0);
        chk("ar_valid", 32'(valid_out), 0);
        chk("ar_ovf", 32'(overflow), 0);
        chk("ar_udf", 32'(underflow), 0);
        chk("ar_full", 32'(full), 0);
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 8'h00, 1'b1);
        chk("ar_read_valid", 32'(valid_out), 0);
        chk("ar_read_udf", 32'(underflow), 1);
        step(1'b1, 8'h42, 1'b0);
        chk("ar_wr_count", 32'(count), 1);
        step(1'b0, 8'h00, 1'b1);
        chk("ar_wr_data", 32'(data_out), 32'h42);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
